// File: rtl/alu_mc_pkg.sv
// Shared definitions for the multi-cycle R-type ALU: funct codes, FSM states
// and small decode helpers.
package alu_mc_pkg;

    localparam int unsigned FUNCT_W = 6;

    localparam logic [FUNCT_W-1:0] F_SLL   = 6'b000000;
    localparam logic [FUNCT_W-1:0] F_SRL   = 6'b000010;
    localparam logic [FUNCT_W-1:0] F_SRA   = 6'b000011;
    localparam logic [FUNCT_W-1:0] F_SLLV  = 6'b000100;
    localparam logic [FUNCT_W-1:0] F_SRLV  = 6'b000110;
    localparam logic [FUNCT_W-1:0] F_SRAV  = 6'b000111;
    localparam logic [FUNCT_W-1:0] F_MFHI  = 6'b010000;
    localparam logic [FUNCT_W-1:0] F_MFLO  = 6'b010010;
    localparam logic [FUNCT_W-1:0] F_MULT  = 6'b011000;
    localparam logic [FUNCT_W-1:0] F_MULTU = 6'b011001;
    localparam logic [FUNCT_W-1:0] F_DIV   = 6'b011010;
    localparam logic [FUNCT_W-1:0] F_DIVU  = 6'b011011;
    localparam logic [FUNCT_W-1:0] F_ADD   = 6'b100000;
    localparam logic [FUNCT_W-1:0] F_ADDU  = 6'b100001;
    localparam logic [FUNCT_W-1:0] F_SUB   = 6'b100010;
    localparam logic [FUNCT_W-1:0] F_SUBU  = 6'b100011;
    localparam logic [FUNCT_W-1:0] F_AND   = 6'b100100;
    localparam logic [FUNCT_W-1:0] F_OR    = 6'b100101;
    localparam logic [FUNCT_W-1:0] F_XOR   = 6'b100110;
    localparam logic [FUNCT_W-1:0] F_NOR   = 6'b100111;
    localparam logic [FUNCT_W-1:0] F_SLT   = 6'b101010;
    localparam logic [FUNCT_W-1:0] F_SLTU  = 6'b101011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    // mult/multu/div/divu share the 0110xx prefix
    function automatic logic is_iterative(input logic [FUNCT_W-1:0] f);
        return f[5:2] == 4'b0110;
    endfunction

    function automatic logic op_is_div(input logic [FUNCT_W-1:0] f);
        return f[1];
    endfunction

    function automatic logic op_is_signed(input logic [FUNCT_W-1:0] f);
        return !f[0];
    endfunction

endpackage

// File: rtl/alu_mc_muldiv.sv
// Shift-add multiplier / restoring divider, one bit per cycle on operand
// magnitudes; signs and divide-by-zero are resolved on the result outputs.
module alu_mc_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             div,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi_c,
    output logic [WIDTH-1:0] lo_c
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned PW = 2 * WIDTH;

    logic             busy;
    logic             div_r;
    logic             neg_q;
    logic             neg_r;
    logic             dz;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] a_r;

    logic             a_neg_c;
    logic             b_neg_c;
    logic [WIDTH-1:0] a_mag_c;
    logic [WIDTH-1:0] b_mag_c;
    logic [WIDTH:0]   madd_c;
    logic [WIDTH:0]   dtry_c;
    logic [WIDTH:0]   dsub_c;
    logic             dge_c;
    logic [PW-1:0]    prod_c;
    logic [PW-1:0]    prod_s_c;
    logic [WIDTH-1:0] quo_c;
    logic [WIDTH-1:0] rem_c;

    assign a_neg_c = sgn && a[WIDTH-1];
    assign b_neg_c = sgn && b[WIDTH-1];
    assign a_mag_c = a_neg_c ? WIDTH'(0) - a : a;
    assign b_mag_c = b_neg_c ? WIDTH'(0) - b : b;

    assign madd_c = {1'b0, acc} + {1'b0, (q[0] ? m : WIDTH'(0))};
    // shift next dividend bit into the partial remainder and trial-subtract
    assign dtry_c = {acc, q[WIDTH-1]};
    assign dsub_c = dtry_c - {1'b0, m};
    assign dge_c  = !dsub_c[WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            div_r <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dz    <= 1'b0;
            cnt   <= '0;
            acc   <= '0;
            q     <= '0;
            m     <= '0;
            a_r   <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                busy  <= 1'b1;
                cnt   <= '0;
                acc   <= '0;
                q     <= a_mag_c;
                m     <= b_mag_c;
                a_r   <= a;
                div_r <= div;
                neg_q <= a_neg_c ^ b_neg_c;
                neg_r <= a_neg_c;
                dz    <= div && (b == WIDTH'(0));
            end else if (busy) begin
                if (div_r) begin
                    acc <= dge_c ? dsub_c[WIDTH-1:0] : dtry_c[WIDTH-1:0];
                    q   <= {q[WIDTH-2:0], dge_c};
                end else begin
                    {acc, q} <= {madd_c, q[WIDTH-1:1]};
                end
                cnt <= cnt + CW'(1);
                if (cnt == CW'(WIDTH - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign prod_c   = {acc, q};
    assign prod_s_c = neg_q ? PW'(0) - prod_c : prod_c;
    assign quo_c    = neg_q ? WIDTH'(0) - q : q;
    assign rem_c    = neg_r ? WIDTH'(0) - acc : acc;

    // results stay valid after done until the next start
    always_comb begin
        hi_c = '0;
        lo_c = '0;
        if (div_r) begin
            if (dz) begin
                lo_c = '1;
                hi_c = a_r;
            end else begin
                lo_c = quo_c;
                hi_c = rem_c;
            end
        end else begin
            {hi_c, lo_c} = prod_s_c;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle MIPS R-type ALU: valid/ready front end, single-cycle ops and
// HI/LO registers; iterative mult/div delegated to alu_mc_muldiv.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic [SHW-1:0]   shamt,
    input  logic [5:0]       funct,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] rd,
    output logic             ovf,
    output logic             err,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t           state;
    logic             accept_c;
    logic             md_start_c;
    logic             md_done;
    logic [WIDTH-1:0] md_hi_c;
    logic [WIDTH-1:0] md_lo_c;
    logic [WIDTH-1:0] sum_c;
    logic [WIDTH-1:0] dif_c;
    logic [WIDTH-1:0] alu_rd_c;
    logic             alu_ovf_c;
    logic             alu_err_c;

    assign in_ready   = rst_n && (state == IDLE) && (!out_valid || out_ready);
    assign accept_c   = in_valid && in_ready;
    assign md_start_c = accept_c && is_iterative(funct);

    alu_mc_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (md_start_c),
        .div   (op_is_div(funct)),
        .sgn   (op_is_signed(funct)),
        .a     (rs),
        .b     (rt),
        .done  (md_done),
        .hi_c  (md_hi_c),
        .lo_c  (md_lo_c)
    );

    assign sum_c = rs + rt;
    assign dif_c = rs - rt;

    // single-cycle result; iterative codes fall through with defaults
    always_comb begin
        alu_rd_c  = '0;
        alu_ovf_c = 1'b0;
        alu_err_c = 1'b0;
        case (funct)
            F_ADD: begin
                alu_rd_c  = sum_c;
                alu_ovf_c = (rs[WIDTH-1] == rt[WIDTH-1]) && (sum_c[WIDTH-1] != rs[WIDTH-1]);
            end
            F_ADDU: alu_rd_c = sum_c;
            F_SUB: begin
                alu_rd_c  = dif_c;
                alu_ovf_c = (rs[WIDTH-1] != rt[WIDTH-1]) && (dif_c[WIDTH-1] != rs[WIDTH-1]);
            end
            F_SUBU:  alu_rd_c = dif_c;
            F_AND:   alu_rd_c = rs & rt;
            F_OR:    alu_rd_c = rs | rt;
            F_XOR:   alu_rd_c = rs ^ rt;
            F_NOR:   alu_rd_c = ~(rs | rt);
            F_SLT:   alu_rd_c = WIDTH'($signed(rs) < $signed(rt));
            F_SLTU:  alu_rd_c = WIDTH'(rs < rt);
            F_SLL:   alu_rd_c = rt << shamt;
            F_SRL:   alu_rd_c = rt >> shamt;
            F_SRA:   alu_rd_c = $signed(rt) >>> shamt;
            F_SLLV:  alu_rd_c = rt << rs[SHW-1:0];
            F_SRLV:  alu_rd_c = rt >> rs[SHW-1:0];
            F_SRAV:  alu_rd_c = $signed(rt) >>> rs[SHW-1:0];
            F_MFHI:  alu_rd_c = hi;
            F_MFLO:  alu_rd_c = lo;
            F_MULT, F_MULTU, F_DIV, F_DIVU: alu_rd_c = '0;
            default: alu_err_c = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            rd        <= '0;
            ovf       <= 1'b0;
            err       <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                    end
                    if (accept_c) begin
                        if (is_iterative(funct)) begin
                            state <= op_is_div(funct) ? DIV : MUL;
                        end else begin
                            out_valid <= 1'b1;
                            rd        <= alu_rd_c;
                            ovf       <= alu_ovf_c;
                            err       <= alu_err_c;
                        end
                    end
                end
                MUL, DIV: begin
                    if (md_done) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    hi        <= md_hi_c;
                    lo        <= md_lo_c;
                    rd        <= md_lo_c;
                    ovf       <= 1'b0;
                    err       <= 1'b0;
                    out_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
